// File: rtl/pchri03_stream_matcher.sv
// Byte-serial, command-driven shift-and (bitap) stream matcher with a small register file.
// Define MATCH_COUNT_EN to build the saturating match counter at register 0x03.
module pchri03_stream_matcher #(
  parameter logic [63:0] ID_STRING = 64'h7063687269303300
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam logic [7:0] CMD_WRITE   = 8'h02;
  localparam logic [7:0] CMD_READ    = 8'h03;
  localparam logic [7:0] CMD_ENABLE  = 8'h81;
  localparam logic [7:0] CMD_STREAM  = 8'h82;
  localparam logic [7:0] CMD_DISABLE = 8'h83;

  typedef enum logic [2:0] {
    IDLE,
    W_ADDR,
    W_DATA,
    R_ADDR,
    S_DATA
  } state_e;

  state_e     state_q, state_d;
  logic [7:0] addr_q, addr_d;
  logic [7:0] uo_q, uo_d;
  logic [7:0] word_size_q, word_size_d;
  logic [7:0] result_mask_q, result_mask_d;
  logic [7:0] char_q [8];
  logic [7:0] char_d [8];
  logic [7:0] mask_q [8];
  logic [7:0] mask_d [8];
  logic [7:0] shift_q, shift_d;
  logic       match_q, match_d;
  logic       enabled_q, enabled_d;
`ifdef MATCH_COUNT_EN
  logic [7:0] count_q, count_d;
`endif

  logic       cs_n;
  logic [3:0] word_size_eff;
  logic [7:0] hit_mask;
  logic [7:0] shift_next;
  logic [7:0] rd_data;
  logic       unused_bits;

  assign cs_n          = uio_in[0];
  assign word_size_eff = (word_size_q > 8'd8) ? 4'd8 : word_size_q[3:0];
  assign unused_bits   = ^{uio_in[7:1], shift_q[7]};

  // Every pattern position that is active and expects the current byte contributes its mask.
  always_comb begin
    hit_mask = '0;
    for (int i = 0; i < 8; i++) begin
      if ((4'(i) < word_size_eff) && (char_q[i] == ui_in)) begin
        hit_mask = hit_mask | mask_q[i];
      end
    end
  end

  assign shift_next = {shift_q[6:0], 1'b1} & hit_mask;

  // Readback mux is addressed by the byte arriving in R_ADDR, so it decodes ui_in directly.
  always_comb begin
    rd_data = 8'h00;
    casez (ui_in)
      8'h00:        rd_data = word_size_q;
      8'h01:        rd_data = result_mask_q;
      8'h02:        rd_data = {6'b0, match_q, enabled_q};
`ifdef MATCH_COUNT_EN
      8'h03:        rd_data = count_q;
`endif
      8'b0000_1???: rd_data = char_q[ui_in[2:0]];
      8'b0001_0???: rd_data = ID_STRING[(7 - int'(ui_in[2:0])) * 8 +: 8];
      default:      rd_data = 8'h00;
    endcase
  end

  // NOTE: every variable gets its hold value first so no path through the case leaves it unassigned, which would infer a latch.
  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    uo_d          = uo_q;
    word_size_d   = word_size_q;
    result_mask_d = result_mask_q;
    char_d        = char_q;
    mask_d        = mask_q;
    shift_d       = shift_q;
    match_d       = match_q;
    enabled_d     = enabled_q;
`ifdef MATCH_COUNT_EN
    count_d       = count_q;
`endif

    if (ena) begin
      if (cs_n) begin
        state_d = IDLE;
      end else begin
        case (state_q)
          IDLE: begin
            case (ui_in)
              CMD_WRITE:  state_d = W_ADDR;
              CMD_READ:   state_d = R_ADDR;
              CMD_STREAM: state_d = S_DATA;
              CMD_ENABLE: begin
                enabled_d = 1'b1;
                shift_d   = '0;
                match_d   = 1'b0;
`ifdef MATCH_COUNT_EN
                count_d   = '0;
`endif
              end
              CMD_DISABLE: enabled_d = 1'b0;
              default: ;
            endcase
          end
          W_ADDR: begin
            addr_d  = ui_in;
            state_d = W_DATA;
          end
          W_DATA: begin
            state_d = IDLE;
            casez (addr_q)
              8'h00:        word_size_d = ui_in;
              8'h01:        result_mask_d = ui_in;
`ifdef MATCH_COUNT_EN
              8'h03:        count_d = '0;
`endif
              8'b0000_1???: char_d[addr_q[2:0]] = ui_in;
              8'b0001_0???: mask_d[addr_q[2:0]] = ui_in;
              default: ;
            endcase
          end
          R_ADDR: begin
            uo_d    = rd_data;
            state_d = IDLE;
          end
          S_DATA: begin
            state_d = IDLE;
            if (enabled_q) begin
              shift_d = shift_next;
              match_d = |(shift_next & result_mask_q);
`ifdef MATCH_COUNT_EN
              if (|(shift_next & result_mask_q) && (count_q != 8'hFF)) begin
                count_d = count_q + 8'd1;
              end
`endif
            end
          end
          default: state_d = IDLE;
        endcase
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples the pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      addr_q        <= '0;
      uo_q          <= '0;
      word_size_q   <= '0;
      result_mask_q <= '0;
      // NOTE: the pattern tables are small flop arrays, not RAM, and power up cleared so a stray ENABLE cannot match garbage.
      char_q        <= '{default: '0};
      mask_q        <= '{default: '0};
      shift_q       <= '0;
      match_q       <= 1'b0;
      enabled_q     <= 1'b0;
`ifdef MATCH_COUNT_EN
      count_q       <= '0;
`endif
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      uo_q          <= uo_d;
      word_size_q   <= word_size_d;
      result_mask_q <= result_mask_d;
      char_q        <= char_d;
      mask_q        <= mask_d;
      shift_q       <= shift_d;
      match_q       <= match_d;
      enabled_q     <= enabled_d;
`ifdef MATCH_COUNT_EN
      count_q       <= count_d;
`endif
    end
  end

  assign uo_out  = uo_q;
  assign uio_out = {5'b0, enabled_q, match_q, 1'b0};
  assign uio_oe  = 8'b0000_0110;

endmodule

// File: tb/tb_pchri03_stream_matcher.sv
// Scoreboard bench for pchri03_stream_matcher: the driver pushes expected pin values per consumed
// byte from a history-based reference model; a negedge monitor pops and compares them.
module tb_pchri03_stream_matcher;

  logic       clk = 1'b0;
  logic       rst;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  pchri03_stream_matcher dut (
    .clk    (clk),
    .rst    (rst),
    .ena    (ena),
    .ui_in  (ui_in),
    .uio_in (uio_in),
    .uo_out (uo_out),
    .uio_out(uio_out),
    .uio_oe (uio_oe)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    int          due;
    logic [7:0]  uo;
    logic [7:0]  uio;
    logic [63:0] tag;
  } exp_t;

  exp_t exp_q [$];
  int   cyc = 0;
  int   compared = 0;
  int   mismatched = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference model state: plain registers plus the per-step hit masks seen since ENABLE.
  logic [7:0] m_ws, m_rm, m_uo, m_cnt;
  logic [7:0] m_char [8];
  logic [7:0] m_mask [8];
  logic       m_en, m_match;
  logic [7:0] hist [$];
  logic [7:0] id_bytes [8] = '{8'h70, 8'h63, 8'h68, 8'h72, 8'h69, 8'h30, 8'h33, 8'h00};

  task automatic check(input logic [63:0] tag, input logic [7:0] act, input logic [7:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %0s @cyc %0d: got 0x%02h, expected 0x%02h", tag, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    while (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
      e = exp_q.pop_front();
      check(e.tag, uo_out, e.uo);
      check(e.tag, uio_out, e.uio);
      check("uio_oe", uio_oe, 8'h06);
    end
  end

  function automatic logic [7:0] model_pins();
    return {5'b0, m_en, m_match, 1'b0};
  endfunction

  function automatic logic [7:0] model_read(input logic [7:0] a);
    if (a == 8'h00) return m_ws;
    if (a == 8'h01) return m_rm;
    if (a == 8'h02) return {6'b0, m_match, m_en};
`ifdef MATCH_COUNT_EN
    if (a == 8'h03) return m_cnt;
`endif
    if (a >= 8'h08 && a <= 8'h0F) return m_char[a - 8'h08];
    if (a >= 8'h10 && a <= 8'h17) return id_bytes[a - 8'h10];
    return 8'h00;
  endfunction

  task automatic model_write(input logic [7:0] a, input logic [7:0] d);
    if (a == 8'h00) m_ws = d;
    else if (a == 8'h01) m_rm = d;
`ifdef MATCH_COUNT_EN
    else if (a == 8'h03) m_cnt = 8'h00;
`endif
    else if (a >= 8'h08 && a <= 8'h0F) m_char[a - 8'h08] = d;
    else if (a >= 8'h10 && a <= 8'h17) m_mask[a - 8'h10] = d;
  endtask

  // Pattern bit j is live iff, for each k<=j, the step j-k bytes ago hit pattern position k.
  task automatic model_step(input logic [7:0] c);
    logic [7:0] b, d;
    int n, ws;
    bit ok;
    if (!m_en) return;
    ws = (m_ws > 8) ? 8 : int'(m_ws);
    b = 8'h00;
    for (int i = 0; i < ws; i++) if (m_char[i] == c) b = b | m_mask[i];
    hist.push_back(b);
    if (hist.size() > 8) void'(hist.pop_front());
    n = hist.size();
    d = 8'h00;
    for (int j = 0; j < 8; j++) begin
      if (n > j) begin
        ok = 1'b1;
        for (int k = 0; k <= j; k++) if (!hist[n - 1 - j + k][k]) ok = 1'b0;
        d[j] = ok;
      end
    end
    m_match = |(d & m_rm);
    if (m_match && m_cnt != 8'hFF) m_cnt = m_cnt + 8'd1;
  endtask

  task automatic expect_pins(input logic [63:0] tag);
    exp_t e;
    e.due = cyc;
    e.uo  = m_uo;
    e.uio = model_pins();
    e.tag = tag;
    exp_q.push_back(e);
  endtask

  // Drives one byte with cs low; returns just after the edge that consumed it.
  task automatic xfer(input logic [7:0] b);
    ena = 1'b1;
    uio_in = 8'h00;
    ui_in = b;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycle();
    ena = 1'b1;
    uio_in = 8'h01;
    ui_in = 8'($urandom);
    @(posedge clk);
    #1;
    expect_pins("cs_idle");
  endtask

  task automatic hold_cycles(input int n);
    ena = 1'b0;
    uio_in = {7'b0, 1'($urandom_range(0, 1))};
    ui_in = 8'($urandom);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      expect_pins("ena_hold");
    end
  endtask

  task automatic do_write(input logic [7:0] a, input logic [7:0] d);
    xfer(8'h02); expect_pins("wr_cmd");
    xfer(a);     expect_pins("wr_addr");
    xfer(d);     model_write(a, d); expect_pins("wr_data");
  endtask

  task automatic do_read(input logic [7:0] a);
    xfer(8'h03); expect_pins("rd_cmd");
    xfer(a);     m_uo = model_read(a); expect_pins("rd_data");
  endtask

  task automatic do_enable();
    xfer(8'h81);
    m_en = 1'b1; m_match = 1'b0; m_cnt = 8'h00; hist.delete();
    expect_pins("enable");
  endtask

  task automatic do_disable();
    xfer(8'h83); m_en = 1'b0; expect_pins("disable");
  endtask

  task automatic do_stream(input logic [7:0] c, input int hold_n);
    xfer(8'h82); expect_pins("st_cmd");
    if (hold_n > 0) hold_cycles(hold_n);
    xfer(c); model_step(c); expect_pins("st_data");
  endtask

  task automatic configure_abc();
    do_write(8'h00, 8'h03);
    do_write(8'h01, 8'h04);
    for (int i = 0; i < 8; i++) begin
      do_write(8'(8'h08 + i), (i < 3) ? 8'(8'h61 + i) : 8'h00);
      do_write(8'(8'h10 + i), (i < 3) ? 8'(1 << i) : 8'h00);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: run did not finish, %0d expectations pending", exp_q.size());
    $fatal(1, "watchdog");
  end

  initial begin
    int op;
    logic [7:0] a, alph [4];
    m_ws = 0; m_rm = 0; m_uo = 0; m_cnt = 0; m_en = 0; m_match = 0;
    for (int i = 0; i < 8; i++) begin m_char[i] = 0; m_mask[i] = 0; end
    rst = 1'b1; ena = 1'b1; uio_in = 8'h01; ui_in = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    expect_pins("reset");

    for (int i = 0; i < 8; i++) do_read(8'(8'h10 + i));

    do_write(8'h00, 8'h03); do_read(8'h00);
    do_write(8'h08, 8'h61); do_read(8'h08);
    do_read(8'h20);

    configure_abc();
    do_enable();
    do_stream(8'h61, 0); do_stream(8'h62, 0); do_stream(8'h63, 0);
    do_stream(8'h64, 0); do_stream(8'h00, 0);
    do_read(8'h03); do_read(8'h02);

    do_enable(); do_disable();
    do_stream(8'h61, 0); do_stream(8'h62, 0); do_stream(8'h63, 0);
    do_read(8'h02);

    // Aborted WRITE: the following byte must be decoded as a command, not data.
    xfer(8'h02); expect_pins("ab_cmd");
    xfer(8'h02); expect_pins("ab_addr");
    idle_cycle();
    xfer(8'h01); expect_pins("ab_ign");
    xfer(8'h02); expect_pins("ab_cmd");
    xfer(8'h00); expect_pins("ab_addr");
    idle_cycle();
    xfer(8'h05); expect_pins("ab_ign");
    do_read(8'h00); do_read(8'h02);

    do_enable();
    do_stream(8'h61, 0);
    hold_cycles(2);
    do_stream(8'h62, 3);
    hold_cycles(2);
    do_stream(8'h63, 1);
    hold_cycles(3);
    do_read(8'h02);

    do_write(8'h00, 8'h00); do_enable();
    do_stream(8'h61, 0); do_stream(8'h62, 0); do_stream(8'h63, 0);
    do_write(8'h00, 8'h0C); do_enable();
    do_stream(8'h61, 0); do_stream(8'h62, 0); do_stream(8'h63, 0);
    do_read(8'h00); do_read(8'h03);

    alph = '{8'h61, 8'h62, 8'h63, 8'h00};
    for (int n = 0; n < 500; n++) begin
      op = $urandom_range(0, 99);
      if (op < 40) do_stream(alph[$urandom_range(0, 3)], ($urandom_range(0, 9) == 0) ? 2 : 0);
      else if (op < 55) begin
        case ($urandom_range(0, 5))
          0: a = 8'h00;
          1: a = 8'h01;
          2: a = 8'h03;
          3: a = 8'(8'h08 + $urandom_range(0, 7));
          4: a = 8'(8'h10 + $urandom_range(0, 7));
          default: a = 8'($urandom);
        endcase
        if (a == 8'h00) do_write(a, 8'($urandom_range(0, 10)));
        else if (a >= 8'h08 && a <= 8'h0F) do_write(a, alph[$urandom_range(0, 3)]);
        else do_write(a, 8'($urandom));
      end
      else if (op < 75) do_read(($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 8'h1F)));
      else if (op < 81) do_enable();
      else if (op < 84) do_disable();
      else if (op < 89) idle_cycle();
      else if (op < 93) hold_cycles($urandom_range(1, 3));
      else if (op < 97) begin
        case ($urandom_range(0, 2))
          0: xfer(8'h02);
          1: xfer(8'h03);
          default: xfer(8'h82);
        endcase
        expect_pins("ab_part");
        idle_cycle();
      end
      else begin
        xfer(8'($urandom_range(8'h04, 8'h80)));
        expect_pins("junk_cmd");
      end
    end

    repeat (3) @(posedge clk);
    #1;
    check("drain", 8'(exp_q.size()), 8'h00);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/pchri03_stream_matcher.md
Name: pchri03_stream_matcher

Overview:
- Byte-serial, command-driven shift-and (bitap) pattern matcher; Tiny Tapeout user-project top level.
- A host writes a configuration register file through a byte-wide command port, one byte per clock while chip-select is low.
- The host then streams data bytes and reads the match result from pins or status registers.

Parameters:
ID_STRING, 64'h7063687269303300 ("pchri03\0", MSB byte = ID0), read-only identification bytes at 0x10-0x17.

Ports:
clk  input  1  system clock; all logic on rising edge.
rst  input  1  synchronous, active-high reset.
ena  input  1  design enable; while low, input bytes are ignored and all state holds.
ui_in  input  8  command/data byte (MOSI), sampled every rising edge when cs is low.
uio_in  input  8  bit 0 = cs (active-low chip select); bits 7:1 unused.
uo_out  output  8  last read-data byte.
uio_out  output  8  bit 1 = match, bit 2 = enabled; all other bits 0.
uio_oe  output  8  constant 8'b0000_0110.

Behaviour:
- Reset: uo_out=0, match=0, enabled=0, parser=IDLE, shift state D=0, all config registers=0, match count=0.
- Command port: one byte consumed per rising edge with ena=1 and cs=0. cs=1 synchronously returns the parser to IDLE and aborts any partial command; config registers are kept.
- Parser FSM states: IDLE, W_ADDR, W_DATA, R_ADDR, S_DATA.
  - IDLE, byte 0x02 (WRITE) -> W_ADDR.
  - IDLE, byte 0x03 (READ) -> R_ADDR.
  - IDLE, byte 0x81 (ENABLE): enabled=1, D=0.
  - IDLE, byte 0x82 (STREAM) -> S_DATA.
  - IDLE, byte 0x83 (DISABLE): enabled=0.
  - IDLE, any other byte: ignored, parser stays in IDLE.
  - W_ADDR: latch address -> W_DATA.
  - W_DATA: write byte to the latched address -> IDLE.
  - R_ADDR: register readback value into uo_out on this edge (visible the following cycle) -> IDLE. uo_out holds until the next READ.
  - S_DATA: if enabled, perform a matcher step with byte c; if not enabled, the byte is dropped. Either way -> IDLE.
- Register map:
  - 0x00 WORD_SIZE: R/W, values >8 are treated as 8.
  - 0x01 RESULT_MASK: R/W.
  - 0x02 STATUS: RO, {6'b0, match, enabled}.
  - 0x03 MATCH_COUNT: see Optional Feature.
  - 0x08-0x0F CHAR0-7: R/W.
  - 0x10-0x17: writes go to MASK0-7 (write-only); reads return ID0-7 from ID_STRING.
  - Other addresses: reads return 0x00, writes are ignored.
- Matcher step (8-bit state D):
  - B = OR of MASKi over all i < WORD_SIZE with CHARi == c; B=0 if there is no hit.
  - D_next = ((D<<1) | 1) & B, truncated to 8 bits.
  - match register <= |(D_next & RESULT_MASK), updated on the same edge, so it is visible one cycle after the data byte is sampled.
  - match holds its value until the next step, ENABLE (clears to 0), or reset.
- WORD_SIZE=0: B is always 0, so match is never asserted.
- Writing config registers while enabled takes effect from the next step; D is not cleared.

Optional Feature:
MATCH_COUNT_EN:
- Defined:
  - 8-bit MATCH_COUNT at 0x03 increments on each step where match becomes or stays 1, saturating at 0xFF.
  - Any write to 0x03 clears it; ENABLE clears it.
- Undefined: the counter does not exist; 0x03 reads 0x00 and writes are ignored.

Test Plan:
- Reset, then READ 0x10..0x17 -> uo_out = 0x70,0x63,0x68,0x72,0x69,0x30,0x33,0x00.
- WRITE 0x00=0x03, then READ 0x00 -> 0x03; WRITE 0x08=0x61, then READ 0x08 -> 0x61; READ 0x20 -> 0x00.
- Configure WORD_SIZE=3, RESULT_MASK=0x04, CHAR0-2=0x61/0x62/0x63, CHAR3-7=0, MASK0-2=0x01/0x02/0x04, MASK3-7=0; ENABLE; STREAM 0x61,0x62,0x63,0x64,0x00 -> match=1 exactly one cycle after 0x63 is sampled, and 0 after 0x64 and after 0x00; MATCH_COUNT=1 (when MATCH_COUNT_EN is defined).
- Same configuration with DISABLE before streaming "abc" -> match stays 0, STATUS=0x00.
- WRITE 0x02 0x01 with cs raised after the address byte, then a new command sequence -> parser restarts in IDLE; 0x01 is decoded as a command (ignored); no register changes.
- ena=0 while streaming "abc" -> D, match and the parser hold; raising ena=1 resumes with the next byte.
